// File: rtl/demux_pkg.sv
// demux_pkg: sel encoding, channel count and sel-to-channel decode shared by the demux slice.
package demux_pkg;
   localparam int NUM_CH = 3;
   localparam logic [1:0] SEL_CH0 = 2'b00;
   localparam logic [1:0] SEL_CH1 = 2'b10;
   localparam logic [1:0] SEL_CH2 = 2'b11;
   // sel[0] only matters when sel[1] is set, so 00 and 01 both land on channel 0
   function automatic logic [1:0] sel_to_ch(input logic [1:0] s);
      return (s == SEL_CH2) ? 2'd2 : (s == SEL_CH1) ? 2'd1 : 2'd0;
   endfunction
endpackage

// File: rtl/demux_1to3_stream_if.sv
// demux_1to3_stream_if: upstream word/select handshake plus three downstream channels.
interface demux_1to3_stream_if #(parameter int WIDTH = 64, parameter int CNT_W = 8);
   logic                       in_valid;
   logic                       in_ready;
   logic [WIDTH-1:0]           din;
   logic [1:0]                 sel;
   logic [2:0]                 out_valid;
   logic [2:0]                 out_ready;
   logic [2:0][WIDTH-1:0]      dout;
   logic [2:0][CNT_W-1:0]      xfer_cnt;
   modport slave (input in_valid, din, sel, out_ready, output in_ready, out_valid, dout, xfer_cnt);
   modport master (output in_valid, din, sel, out_ready, input in_ready, out_valid, dout, xfer_cnt);
endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry channel buffer with a saturating transfer counter.
module demux_slot #(parameter int WIDTH = 64, parameter int CNT_W = 8) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk) begin
      if (reset) begin
         full <= 1'b0;
         data <= '0;
         cnt  <= '0;
      end else begin
         full <= wr_en | (full & ~rd_en);
         if (wr_en) data <= din;
         cnt  <= cnt + CNT_W'(rd_en & ~&cnt);
      end
   end
endmodule

// File: rtl/demux_1to3_stream.sv
// demux_1to3_stream: routes an upstream stream to one of three independently buffered channels.
module demux_1to3_stream
   import demux_pkg::*;
#(parameter int WIDTH = 64, parameter int CNT_W = 8) (
   input logic              clk,
   input logic              reset,
   demux_1to3_stream_if.slave bus
);
   logic [1:0]        ch;
   logic [NUM_CH-1:0] full, wr_en, rd_en;
   // a full slot still accepts when it drains in the same cycle
   always_comb begin
      ch = sel_to_ch(bus.sel);
      bus.in_ready = ~reset & (~full[ch] | bus.out_ready[ch]);
   end
   assign bus.out_valid = full;
   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      assign wr_en[k] = bus.in_valid & bus.in_ready & (ch == 2'(k));
      assign rd_en[k] = full[k] & bus.out_ready[k];
      demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
         .clk   (clk),
         .reset (reset),
         .wr_en (wr_en[k]),
         .rd_en (rd_en[k]),
         .din   (bus.din),
         .full  (full[k]),
         .data  (bus.dout[k]),
         .cnt   (bus.xfer_cnt[k])
      );
   end
endmodule
